spi_master: RTL and testbench

Byte-oriented SPI master, mode 0 (CPOL=0, CPHA=0), that consumes the one-cycle `tick` pulse from the clock divider stage feeding it. Each tick advances the serial clock by one half-period. The host side is a start/busy/done handshake. The block sits between the divider and the chip's SPI pins.

---
 rtl/spi_master_pkg.sv | 12 +
 rtl/spi_master_if.sv | 24 ++
 rtl/spi_master_shreg.sv | 44 ++++
 rtl/spi_master.sv | 183 ++++++++++++++++++
 tb/tb_spi_master.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_master_pkg.sv
// Shared constants for the SPI master: frame width default and FSM state encoding.
// Optional full-duplex receive path is enabled by defining SPI_MISO_EN.
package spi_master_pkg;

    localparam int SPI_DW_DEFAULT = 8;

    localparam logic [1:0] SPI_IDLE = 2'd0;
    localparam logic [1:0] SPI_LOW  = 2'd1;
    localparam logic [1:0] SPI_HIGH = 2'd2;
    localparam logic [1:0] SPI_HOLD = 2'd3;

endpackage

// File: rtl/spi_master_if.sv
// Host-side start/busy/done handshake of the SPI master.
// With SPI_MISO_EN defined the received word is carried here as well.
interface spi_master_if
    import spi_master_pkg::*;
#(
    parameter int DW = SPI_DW_DEFAULT
);

    logic          start;
    logic [DW-1:0] data_in;
    logic          busy;
    logic          done;

`ifdef SPI_MISO_EN
    logic [DW-1:0] data_out;

    modport master (output start, output data_in, input busy, input done, input data_out);
    modport slave  (input start, input data_in, output busy, output done, output data_out);
`else
    modport master (output start, output data_in, input busy, input done);
    modport slave  (input start, input data_in, output busy, output done);
`endif

endinterface

// File: rtl/spi_master_shreg.sv
// DW-bit shift register with parallel load (priority), shift-left and serial-in LSB.
// Used for the transmit word and, when SPI_MISO_EN is defined, the receive word.
module spi_master_shreg
    import spi_master_pkg::*;
#(
    parameter int DW = SPI_DW_DEFAULT
)
(
    input  logic          clk,
    input  logic          rstn,
    input  logic          load,
    input  logic          shift,
    input  logic          sin,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] q
);

    logic [DW-1:0] sh_q;
    logic [DW-1:0] sh_d;

    // Next-state: load wins over shift, otherwise hold.
    always_comb begin
        sh_d = sh_q;
        if (load) begin
            sh_d = din;
        end else if (shift) begin
            sh_d = {sh_q[DW-2:0], sin};
        end else begin
            sh_d = sh_q;
        end
    end

    // Shift register state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sh_q <= {DW{1'b0}};
        end else begin
            sh_q <= sh_d;
        end
    end

    assign q = sh_q;

endmodule

// File: rtl/spi_master.sv
// Byte-oriented SPI mode-0 master advanced one half SCLK period per divider tick.
// Define SPI_MISO_EN for full duplex (miso input, data_out on the host interface).
module spi_master
    import spi_master_pkg::*;
#(
    parameter int DW = SPI_DW_DEFAULT
)
(
    input  logic         clk,
    input  logic         rstn,
    input  logic         tick,
    spi_master_if.slave  host,
    output logic         sclk,
    output logic         mosi,
    output logic         cs_n
`ifdef SPI_MISO_EN
    ,
    input  logic         miso
`endif
);

    localparam int CW = $clog2(DW);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sclk_q, sclk_d;
    logic          cs_n_q, cs_n_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          tx_load_s;
    logic          tx_shift_s;
    logic [DW-1:0] tx_din_s;
    logic [DW-1:0] tx_s;

    // FSM next-state and output decode; non-IDLE states only move on tick.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sclk_d     = sclk_q;
        cs_n_d     = cs_n_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        tx_load_s  = 1'b0;
        tx_shift_s = 1'b0;
        tx_din_s   = host.data_in;
        case (state_q)
            SPI_IDLE: begin
                if (host.start) begin
                    tx_load_s = 1'b1;
                    cnt_d     = {CW{1'b0}};
                    busy_d    = 1'b1;
                    cs_n_d    = 1'b0;
                    state_d   = SPI_LOW;
                end else begin
                    state_d = SPI_IDLE;
                end
            end
            SPI_LOW: begin
                if (tick) begin
                    sclk_d  = 1'b1;
                    state_d = SPI_HIGH;
                end else begin
                    state_d = SPI_LOW;
                end
            end
            SPI_HIGH: begin
                if (tick) begin
                    sclk_d = 1'b0;
                    if (cnt_q == CW'(DW - 1)) begin
                        state_d = SPI_HOLD;
                    end else begin
                        tx_shift_s = 1'b1;
                        cnt_d      = cnt_q + CW'(1);
                        state_d    = SPI_LOW;
                    end
                end else begin
                    state_d = SPI_HIGH;
                end
            end
            SPI_HOLD: begin
                if (tick) begin
                    // Clearing the transmit register returns mosi to 0.
                    tx_load_s = 1'b1;
                    tx_din_s  = {DW{1'b0}};
                    cs_n_d    = 1'b1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    state_d   = SPI_IDLE;
                end else begin
                    state_d = SPI_HOLD;
                end
            end
            default: begin
                tx_load_s = 1'b1;
                tx_din_s  = {DW{1'b0}};
                sclk_d    = 1'b0;
                cs_n_d    = 1'b1;
                busy_d    = 1'b0;
                state_d   = SPI_IDLE;
            end
        endcase
    end

    // FSM and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= SPI_IDLE;
            cnt_q   <= {CW{1'b0}};
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // The MSB of the transmit register is the mosi flop itself.
    spi_master_shreg #(.DW(DW)) u_tx (
        .clk   (clk),
        .rstn  (rstn),
        .load  (tx_load_s),
        .shift (tx_shift_s),
        .sin   (1'b0),
        .din   (tx_din_s),
        .q     (tx_s)
    );

    assign sclk      = sclk_q;
    assign mosi      = tx_s[DW-1];
    assign cs_n      = cs_n_q;
    assign host.busy = busy_q;
    assign host.done = done_q;

`ifdef SPI_MISO_EN
    logic          rx_load_s;
    logic          rx_shift_s;
    logic          frame_end_s;
    logic [DW-1:0] rx_s;
    logic [DW-1:0] data_out_q, data_out_d;

    assign rx_load_s   = (state_q == SPI_IDLE) && host.start;
    assign rx_shift_s  = (state_q == SPI_LOW)  && tick;
    assign frame_end_s = (state_q == SPI_HOLD) && tick;

    spi_master_shreg #(.DW(DW)) u_rx (
        .clk   (clk),
        .rstn  (rstn),
        .load  (rx_load_s),
        .shift (rx_shift_s),
        .sin   (miso),
        .din   ({DW{1'b0}}),
        .q     (rx_s)
    );

    // Received word is published only on the done cycle.
    always_comb begin
        if (frame_end_s) begin
            data_out_d = rx_s;
        end else begin
            data_out_d = data_out_q;
        end
    end

    // Received word register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_out_q <= {DW{1'b0}};
        end else begin
            data_out_q <= data_out_d;
        end
    end

    assign host.data_out = data_out_q;
`endif

endmodule

// File: tb/tb_spi_master.sv
// Directed, table-driven bench for spi_master (DW=8); loopback checks run when SPI_MISO_EN is defined.
module tb_spi_master;

    logic clk = 1'b0;
    logic rstn;
    logic tick;
    logic sclk;
    logic mosi;
    logic cs_n;
    int   errors = 0;
    int   checks = 0;

    spi_master_if #(.DW(8)) bus ();

`ifdef SPI_MISO_EN
    logic miso;
    logic loop_mode = 1'b0;
    logic miso_hold = 1'b0;
    assign miso = loop_mode ? mosi : miso_hold;
`endif

    spi_master #(.DW(8)) dut (
        .clk  (clk),
        .rstn (rstn),
        .tick (tick),
        .host (bus),
        .sclk (sclk),
        .mosi (mosi),
        .cs_n (cs_n)
`ifdef SPI_MISO_EN
        ,
        .miso (miso)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         period;
        bit         tick_acc;
        int         inj;
        logic [7:0] exp_pat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One frame: accept, counted ticks every 'period' cycles, optional start pulse on tick 'inj'.
    task automatic run_frame(input logic [7:0] d, input int period, input bit tick_acc,
                             input int inj, input bit lp, input bit mval,
                             output logic [7:0] pat, output int nrise, output int ndone,
                             output int done_tick, output logic cs_at_done,
                             output logic busy_at_done, output logic mosi_at_done,
                             output logic [7:0] rx_at_done);
        int   ticks;
        logic sclk_prev;
        bit   injected;
        pat = 8'h00; nrise = 0; ndone = 0; done_tick = -1;
        cs_at_done = 1'b0; busy_at_done = 1'b1; mosi_at_done = 1'b1; rx_at_done = 8'h00;
        injected = 1'b0;
`ifdef SPI_MISO_EN
        loop_mode = lp;
        miso_hold = mval;
`endif
        bus.start = 1'b1;
        bus.data_in = d;
        tick = tick_acc;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.data_in = ~d;
        tick = 1'b0;
        ticks = 0;
        sclk_prev = sclk;
        for (int cyc = 0; cyc < 17 * period + 40; cyc++) begin
            tick = ((cyc % period) == (period - 1));
            if (inj > 0 && tick && ticks == inj - 1 && !injected) begin
                bus.start = 1'b1;
                bus.data_in = 8'h3C;
                injected = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            if (tick) ticks++;
            #1;
            if (!sclk_prev && sclk) begin
                pat = {pat[6:0], mosi};
                nrise++;
            end
            sclk_prev = sclk;
            if (bus.done) begin
                ndone++;
                if (ndone == 1) begin
                    done_tick = ticks;
                    cs_at_done = cs_n;
                    busy_at_done = bus.busy;
                    mosi_at_done = mosi;
`ifdef SPI_MISO_EN
                    rx_at_done = bus.data_out;
`endif
                end
            end
        end
        tick = 1'b0;
        bus.start = 1'b0;
    endtask

    vec_t       vecs[5];
    logic [7:0] pat, rx;
    int         nrise, ndone, dtick;
    logic       csd, bsd, msd;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{data: 8'hA5, period: 4, tick_acc: 1'b0, inj: 0, exp_pat: 8'hA5};
        vecs[1] = '{data: 8'h3C, period: 1, tick_acc: 1'b0, inj: 0, exp_pat: 8'h3C};
        vecs[2] = '{data: 8'h81, period: 3, tick_acc: 1'b1, inj: 0, exp_pat: 8'h81};
        vecs[3] = '{data: 8'hA5, period: 2, tick_acc: 1'b0, inj: 5, exp_pat: 8'hA5};
        vecs[4] = '{data: 8'h7E, period: 5, tick_acc: 1'b0, inj: 0, exp_pat: 8'h7E};

        // Reset held with start asserted and tick toggling.
        rstn = 1'b0;
        tick = 1'b0;
        bus.start = 1'b1;
        bus.data_in = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            tick = ~tick;
            @(posedge clk); #1;
            check("reset_outputs", {27'd0, cs_n, sclk, mosi, bus.busy, bus.done}, 32'b10000);
        end
`ifdef SPI_MISO_EN
        check("reset_data_out", {24'd0, bus.data_out}, 32'h0);
`endif
        bus.start = 1'b0;
        tick = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        check("idle_after_reset", {29'd0, cs_n, bus.busy, mosi}, 32'b100);

        // Table-driven transmit frames.
        for (int v = 0; v < 5; v++) begin
            run_frame(vecs[v].data, vecs[v].period, vecs[v].tick_acc, vecs[v].inj, 1'b0, 1'b0,
                      pat, nrise, ndone, dtick, csd, bsd, msd, rx);
            check($sformatf("v%0d_pattern", v), {24'd0, pat}, {24'd0, vecs[v].exp_pat});
            check($sformatf("v%0d_rises", v), nrise, 32'd8);
            check($sformatf("v%0d_done_count", v), ndone, 32'd1);
            check($sformatf("v%0d_done_tick", v), dtick, 32'd17);
            check($sformatf("v%0d_cs_at_done", v), {31'd0, csd}, 32'd1);
            check($sformatf("v%0d_busy_at_done", v), {31'd0, bsd}, 32'd0);
            check($sformatf("v%0d_mosi_at_done", v), {31'd0, msd}, 32'd0);
        end

`ifdef SPI_MISO_EN
        // Loopback, then miso held high.
        run_frame(8'h3C, 2, 1'b0, 0, 1'b1, 1'b0, pat, nrise, ndone, dtick, csd, bsd, msd, rx);
        check("loop_data_out", {24'd0, rx}, 32'h3C);
        run_frame(8'h12, 3, 1'b0, 0, 1'b0, 1'b1, pat, nrise, ndone, dtick, csd, bsd, msd, rx);
        check("ones_data_out", {24'd0, rx}, 32'hFF);
        repeat (5) @(posedge clk);
        #1;
        check("data_out_hold", {24'd0, bus.data_out}, 32'hFF);
        loop_mode = 1'b0;
        miso_hold = 1'b0;
`endif

        // Back-to-back frames with start held and tick tied high.
        begin
            int  last_done, nd, low_run, high_run;
            bit  seen_high;
            last_done = -1; nd = 0; low_run = 0; high_run = 0; seen_high = 1'b0;
            bus.start = 1'b1;
            bus.data_in = 8'hC3;
            tick = 1'b1;
            for (int cyc = 0; cyc < 80; cyc++) begin
                @(posedge clk); #1;
                if (bus.done) begin
                    if (last_done >= 0) check("b2b_done_period", cyc - last_done, 32'd18);
                    check("b2b_cs_at_done", {31'd0, cs_n}, 32'd1);
                    last_done = cyc;
                    nd++;
                end
                if (bus.busy) begin
                    if (seen_high && low_run != 0) check("b2b_gap", low_run, 32'd1);
                    seen_high = 1'b1;
                    high_run++;
                    low_run = 0;
                end else begin
                    if (high_run > 0) check("b2b_busy_len", high_run, 32'd17);
                    high_run = 0;
                    low_run++;
                end
            end
            check("b2b_frames", {31'd0, nd >= 4}, 32'd1);
            bus.start = 1'b0;
            for (int cyc = 0; cyc < 40 && bus.busy; cyc++) begin
                @(posedge clk); #1;
            end
            check("b2b_drain_idle", {31'd0, bus.busy}, 32'd0);
            tick = 1'b0;
        end

        // Reset after the third rising sclk.
        begin
            int   rises, dcount;
            logic sp;
            rises = 0; dcount = 0;
            bus.start = 1'b1;
            bus.data_in = 8'h55;
            @(posedge clk); #1;
            bus.start = 1'b0;
            sp = sclk;
            for (int cyc = 0; cyc < 100 && rises < 3; cyc++) begin
                tick = ~tick;
                @(posedge clk); #1;
                if (!sp && sclk) rises++;
                sp = sclk;
                if (bus.done) dcount++;
            end
            check("midrst_reached_rise3", rises, 32'd3);
            #2;
            rstn = 1'b0;
            #1;
            check("midrst_outputs", {27'd0, cs_n, sclk, mosi, bus.busy, bus.done}, 32'b10000);
            for (int i = 0; i < 4; i++) begin
                @(posedge clk); #1;
                if (bus.done) dcount++;
            end
            #2;
            rstn = 1'b1;
            tick = 1'b0;
            for (int i = 0; i < 4; i++) begin
                @(posedge clk); #1;
                if (bus.done) dcount++;
            end
            check("midrst_no_done", dcount, 32'd0);
            run_frame(8'h0F, 2, 1'b0, 0, 1'b0, 1'b0, pat, nrise, ndone, dtick, csd, bsd, msd, rx);
            check("after_rst_pattern", {24'd0, pat}, 32'h0F);
            check("after_rst_done_count", ndone, 32'd1);
            check("after_rst_done_tick", dtick, 32'd17);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
